// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, immediate extension, load-use stall and bubble insertion.
// Optional feature macro: ID_EX_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [5:0]            id_opcode,
    input  logic [5:0]            id_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [15:0]           id_imm,
    input  logic [4:0]            id_shamt,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [3:0]            alu_ctl,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [4:0]            alu_shamt,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg
);

    logic                  valid_q;
    logic [3:0]            alu_ctl_q, alu_ctl_d;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, dest_q, dest_d;
    logic [DATA_W-1:0]     rs_data_q, rt_data_q, imm_ext_q, imm_ext_d;
    logic [4:0]            shamt_q;
    logic                  alu_src_q;
    logic                  reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
    logic [DATA_W-1:0]     rs_fwd, rt_fwd;

    always_comb begin
        alu_ctl_d = 4'd15;
        case (id_alu_op)
            2'b00: alu_ctl_d = 4'd2;
            2'b01: alu_ctl_d = 4'd6;
            2'b10: begin
                case (id_funct)
                    6'h20:   alu_ctl_d = 4'd2;
                    6'h22:   alu_ctl_d = 4'd6;
                    6'h24:   alu_ctl_d = 4'd0;
                    6'h25:   alu_ctl_d = 4'd1;
                    6'h2A:   alu_ctl_d = 4'd7;
                    6'h27:   alu_ctl_d = 4'd12;
                    6'h00:   alu_ctl_d = 4'd10;
                    default: alu_ctl_d = 4'd15;
                endcase
            end
            default: begin
                case (id_opcode)
                    6'h08:   alu_ctl_d = 4'd2;
                    6'h0C:   alu_ctl_d = 4'd0;
                    6'h0D:   alu_ctl_d = 4'd1;
                    6'h0A:   alu_ctl_d = 4'd7;
                    default: alu_ctl_d = 4'd15;
                endcase
            end
        endcase
    end

    // Logical immediates (andi/ori) zero-extend; everything else sign-extends.
    always_comb begin
        if (id_opcode == 6'h0C || id_opcode == 6'h0D)
            imm_ext_d = {{(DATA_W-16){1'b0}}, id_imm};
        else
            imm_ext_d = {{(DATA_W-16){id_imm[15]}}, id_imm};
        dest_d = id_reg_dst ? id_rd : id_rt;
    end

    assign stall = valid_q & mem_read_q & id_valid & (dest_q != '0)
                 & ((dest_q == id_rs) | (dest_q == id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            alu_ctl_q    <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            dest_q       <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_ext_q    <= '0;
            shamt_q      <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (flush || stall) begin
            valid_q      <= 1'b0;
            alu_ctl_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= id_valid;
            alu_ctl_q    <= alu_ctl_d;
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            dest_q       <= dest_d;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_ext_q    <= imm_ext_d;
            shamt_q      <= id_shamt;
            alu_src_q    <= id_alu_src;
            reg_write_q  <= id_reg_write;
            mem_read_q   <= id_mem_read;
            mem_write_q  <= id_mem_write;
            mem_to_reg_q <= id_mem_to_reg;
        end
    end

`ifdef ID_EX_FORWARD_EN
    // The younger EX/MEM result takes precedence over MEM/WB; register 0 is never forwarded.
    always_comb begin
        rs_fwd = rs_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q)
            rs_fwd = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q)
            rs_fwd = memwb_result;

        rt_fwd = rt_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q)
            rt_fwd = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q)
            rt_fwd = memwb_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result, rs_q, rt_q};
    assign rs_fwd = rs_data_q;
    assign rt_fwd = rt_data_q;
`endif

    assign ex_valid      = valid_q;
    assign alu_ctl       = alu_ctl_q;
    assign alu_a         = rs_fwd;
    assign alu_b         = alu_src_q ? imm_ext_q : rt_fwd;
    assign alu_shamt     = shamt_q;
    assign ex_store_data = rt_fwd;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;

    logic        clk, rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, ex_valid;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_shamt, ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int errors = 0;
    int checks = 0;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .ex_valid(ex_valid), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shamt(alu_shamt), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_id();
        id_valid = 0; id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_alu_op = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic step(input string name);
        @(posedge clk);
        #1;
        $display("step %s: ex_valid=%0b alu_ctl=%0d a=%h b=%h dest=%0d stall=%0b",
                 name, ex_valid, alu_ctl, alu_a, alu_b, ex_dest, stall);
    endtask

    task automatic set_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [5:0] funct, input logic [4:0] shamt);
        clr_id();
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_funct = funct; id_shamt = shamt; id_alu_op = 2'b10; id_reg_dst = 1; id_reg_write = 1;
    endtask

    task automatic set_i(input logic [5:0] opc, input logic [1:0] aop, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] rsd, input logic [15:0] imm);
        clr_id();
        id_valid = 1; id_opcode = opc; id_alu_op = aop; id_rs = rs; id_rt = rt;
        id_rs_data = rsd; id_imm = imm; id_alu_src = 1; id_reg_write = 1;
    endtask

    task automatic set_lw(input logic [4:0] rt);
        set_i(6'h23, 2'b00, 5'd1, rt, 32'd5, 16'd4);
        id_mem_read = 1; id_mem_to_reg = 1;
    endtask

    initial begin
        rst_n = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
        clr_id();
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);

        // Reset asserted while a load-use stall is pending
        @(negedge clk); rst_n = 1;
        set_lw(5'd3);
        step("lw");
        chk("lw_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        set_r(5'd3, 5'd2, 5'd4, 32'd9, 32'd7, 6'h20, 5'd0);
        #1;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_mid_mem_read", {31'd0, ex_mem_read}, 32'd0);
        chk("rst_mid_dest", {27'd0, ex_dest}, 32'd0);
        chk("rst_mid_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        chk("rst_mid_alu_b", alu_b, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        id_valid = 0;
        @(posedge clk); #1; rst_n = 1; #1;
        chk("rel_stall", {31'd0, stall}, 32'd0);

        // add r3 = r1 + r2
        set_r(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'h20, 5'd0);
        step("add");
        chk("add_alu_ctl", {28'd0, alu_ctl}, 32'd2);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_dest", {27'd0, ex_dest}, 32'd3);
        chk("add_reg_write", {31'd0, ex_reg_write}, 32'd1);
        chk("add_ex_valid", {31'd0, ex_valid}, 32'd1);

        // Forwarding priority on rs=1
        clr_id();
        exmem_reg_write = 1; exmem_rd = 1; exmem_result = 32'h10;
        memwb_reg_write = 1; memwb_rd = 1; memwb_result = 32'h20;
        #1;
        chk("fwd_exmem", alu_a, FWD ? 32'h10 : 32'd5);
        exmem_reg_write = 0; #1;
        chk("fwd_memwb", alu_a, FWD ? 32'h20 : 32'd5);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0; #1;
        chk("fwd_r0", alu_a, 32'd5);
        exmem_rd = 2; #1;
        chk("fwd_store", ex_store_data, FWD ? 32'h10 : 32'd7);
        chk("fwd_alu_b", alu_b, FWD ? 32'h10 : 32'd7);
        exmem_reg_write = 0; exmem_rd = 0; memwb_reg_write = 0;

        // Load-use: lw r3 then add using r3
        set_lw(5'd3);
        step("lw");
        chk("lw_dest", {27'd0, ex_dest}, 32'd3);
        chk("lw_alu_b", alu_b, 32'd4);
        chk("lw_alu_ctl", {28'd0, alu_ctl}, 32'd2);
        set_r(5'd3, 5'd2, 5'd4, 32'd9, 32'd7, 6'h20, 5'd0);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        step("bubble");
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        chk("lu_bubble_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("lu_stall_clear", {31'd0, stall}, 32'd0);
        step("add_issue");
        chk("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_issue_dest", {27'd0, ex_dest}, 32'd4);
        chk("lu_issue_alu_a", alu_a, 32'd9);

        // Flush together with stall
        set_lw(5'd3);
        step("lw");
        set_i(6'h2B, 2'b00, 5'd1, 5'd3, 32'd5, 16'd8);
        id_reg_write = 0; id_mem_write = 1;
        flush = 1;
        #1;
        chk("fs_stall", {31'd0, stall}, 32'd1);
        step("flush");
        flush = 0;
        chk("fs_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("fs_reg_write", {31'd0, ex_reg_write}, 32'd0);
        chk("fs_mem_write", {31'd0, ex_mem_write}, 32'd0);
        chk("fs_mem_read", {31'd0, ex_mem_read}, 32'd0);
        chk("fs_alu_ctl", {28'd0, alu_ctl}, 32'd0);

        // Immediates, shifts and decode corners
        set_i(6'h0C, 2'b11, 5'd1, 5'd5, 32'd5, 16'h8000);
        step("andi");
        chk("andi_alu_b", alu_b, 32'h0000_8000);
        chk("andi_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        set_i(6'h08, 2'b11, 5'd1, 5'd5, 32'd5, 16'h8000);
        step("addi");
        chk("addi_alu_b", alu_b, 32'hFFFF_8000);
        chk("addi_alu_ctl", {28'd0, alu_ctl}, 32'd2);
        set_i(6'h0D, 2'b11, 5'd1, 5'd6, 32'd5, 16'h8001);
        step("ori");
        chk("ori_alu_b", alu_b, 32'h0000_8001);
        chk("ori_alu_ctl", {28'd0, alu_ctl}, 32'd1);
        chk("ori_dest", {27'd0, ex_dest}, 32'd6);
        set_r(5'd0, 5'd2, 5'd7, 32'd0, 32'd3, 6'h00, 5'd4);
        step("sll");
        chk("sll_alu_ctl", {28'd0, alu_ctl}, 32'd10);
        chk("sll_shamt", {27'd0, alu_shamt}, 32'd4);
        set_r(5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 6'h27, 5'd0);
        step("nor");
        chk("nor_alu_ctl", {28'd0, alu_ctl}, 32'd12);
        set_r(5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 6'h2A, 5'd0);
        step("slt");
        chk("slt_alu_ctl", {28'd0, alu_ctl}, 32'd7);
        set_r(5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 6'h3F, 5'd0);
        step("bad_funct");
        chk("bad_funct_alu_ctl", {28'd0, alu_ctl}, 32'd15);
        set_i(6'h04, 2'b01, 5'd1, 5'd2, 32'd5, 16'hFFFF);
        id_alu_src = 0; id_reg_write = 0; id_rt_data = 32'd5;
        step("beq");
        chk("beq_alu_ctl", {28'd0, alu_ctl}, 32'd6);
        chk("beq_alu_b", alu_b, 32'd5);
        set_i(6'h3E, 2'b11, 5'd1, 5'd2, 32'd5, 16'h0001);
        step("bad_opcode");
        chk("bad_opcode_alu_ctl", {28'd0, alu_ctl}, 32'd15);
        clr_id();
        step("idle");
        chk("idle_ex_valid", {31'd0, ex_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage that feeds the 32-bit ALU. It registers decoded ID-stage fields, produces the 4-bit ALU control code, and drives the ALU operands. Operands come from register data or the immediate, with EX/MEM and MEM/WB forwarding applied. The stage detects load-use hazards, stalls the front end, and inserts bubbles on stall or branch flush.

Parameters:
DATA_W, 32, datapath width (ALU operands/results)
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  6  instruction opcode
id_funct  in  6  R-type funct
id_rs / id_rt / id_rd  in  5 each  register specifiers
id_rs_data / id_rt_data  in  DATA_W each  register-file read data
id_imm  in  16  raw immediate
id_shamt  in  5  shift amount
id_alu_op  in  2  main-decoder ALUOp
id_alu_src  in  1  1 = B from immediate
id_reg_dst  in  1  1 = dest rd, 0 = dest rt
id_reg_write / id_mem_read / id_mem_write / id_mem_to_reg  in  1 each  control bits
flush  in  1  taken branch/jump; kill ID instruction
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  5  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  5  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback value
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
alu_ctl  out  4  ALU control code
alu_a / alu_b  out  DATA_W each  ALU operands
alu_shamt  out  5  ALU shift amount
ex_store_data  out  DATA_W  forwarded rt value for sw
ex_dest  out  5  destination register
ex_reg_write / ex_mem_read / ex_mem_write / ex_mem_to_reg  out  1 each  registered control bits

Behaviour:
- Reset (rst_n low, asynchronous): all registered state = 0. Outputs ex_valid, alu_ctl, alu_shamt, ex_dest and all ex_* control bits = 0; alu_a = alu_b = ex_store_data = 0 (no forward for register 0). Reset mid-stall discards the pending instruction.
- stall (combinational) = ex_valid & ex_mem_read & id_valid & ex_dest != 0 & (ex_dest == id_rs | ex_dest == id_rt).
- Clock-edge priority: reset > flush > stall > capture.
  - flush or stall: bubble. ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_mem_to_reg load 0; alu_ctl loads 0.
  - Otherwise: capture all ID fields; ex_valid <= id_valid.
  - Simultaneous flush and stall: bubble; stall still asserted for that cycle.
- Latency: one cycle, ID to EX.
- alu_ctl is decoded at capture:
  - ALUOp 00 -> 2 (add: lw/sw).
  - ALUOp 01 -> 6 (sub: beq).
  - ALUOp 10 by funct: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x2A->7, 0x27->12, 0x00->10; any other funct -> 15.
  - ALUOp 11 by opcode: 0x08->2, 0x0C->0, 0x0D->1, 0x0A->7; any other opcode -> 15.
- Immediate extension at capture: zero-extend for opcodes 0x0C and 0x0D; sign-extend otherwise.
- ex_dest = id_reg_dst ? id_rd : id_rt, computed at capture.
- Forwarding (combinational on the registered rs and rt):
  - EX/MEM wins if exmem_reg_write & exmem_rd != 0 & match.
  - Else MEM/WB if memwb_reg_write & memwb_rd != 0 & match.
  - Else the registered register data.
- alu_a = forwarded rs. alu_b = alu_src ? extended immediate : forwarded rt. ex_store_data = forwarded rt. alu_shamt = registered shamt.

Optional Feature:
ID_EX_FORWARD_EN
- Defined: forwarding as described above.
- Undefined: no forwarding muxes; alu_a, alu_b and ex_store_data use the registered register data only. Load-use stall logic is unchanged. RAW hazards are resolved by software NOPs.

Test Plan:
- rst_n low during a stall cycle -> all outputs 0 immediately; stall = 0 after release with id_valid = 0.
- add: rs=1 (data 5), rt=2 (data 7), rd=3, ALUOp 10, funct 0x20 -> next cycle alu_ctl=2, alu_a=5, alu_b=7, ex_dest=3, ex_reg_write=1.
- Forwarding: EX rs=1; exmem_rd=1 with result 0x10 and memwb_rd=1 with result 0x20, both writing -> alu_a=0x10. With exmem_reg_write=0 -> 0x20. With both rd=0 -> registered data.
- Load-use: EX lw with ex_dest=3; ID add with rs=3 -> stall=1 for one cycle and ex_valid=0 next. Instruction issues the following cycle with stall=0.
- flush and stall in the same cycle -> next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0, alu_ctl=0.
- Immediates and shift:
  - andi with imm 0x8000 -> alu_b=0x00008000, alu_ctl=0.
  - addi with imm 0x8000 -> alu_b=0xFFFF8000, alu_ctl=2.
  - sll with shamt 4 -> alu_ctl=10, alu_shamt=4.
